// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/execute sequencer: opcode map, FSM state
// encoding and the instruction-width derivation.
package cpu_pkg;

    localparam int OPCODE_W = 4;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SUBI = 4'h3;
    localparam logic [3:0] OP_STA  = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_LDA  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_ORI  = 4'h8;
    localparam logic [3:0] OP_AND  = 4'h9;
    localparam logic [3:0] OP_ANDI = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    function automatic int instr_width(input int operand_w);
        return OPCODE_W + operand_w;
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Bundle of everything the sequencer exchanges with program memory, the control
// unit, the datapath and data RAM. master = sequencer side, slave = environment.
interface cpu_sequencer_if #(
    parameter int ADDR_W    = 4,
    parameter int OPERAND_W = 4,
    parameter int DATA_W    = 8
);
    import cpu_pkg::*;

    localparam int INSTR_W = instr_width(OPERAND_W);

    logic                 run;
    logic [ADDR_W-1:0]    imem_addr;
    logic                 imem_rd;
    logic [INSTR_W-1:0]   imem_data;
    logic [3:0]           opcode;
    logic [OPERAND_W-1:0] operand;
    logic                 mem_read;
    logic                 mem_write;
    logic                 acc_write;
    logic                 pc_load;
    logic                 use_immed;
    logic                 dmem_req;
    logic                 dmem_we;
    logic [OPERAND_W-1:0] dmem_addr;
    logic [DATA_W-1:0]    dmem_rdata;
    logic                 dmem_ack;
    logic [DATA_W-1:0]    mdr_q;
    logic                 alu_b_sel;
    logic                 acc_we;
    logic [ADDR_W-1:0]    pc;
    logic                 halted;

    modport master (
        input  run, imem_data, mem_read, mem_write, acc_write, pc_load, use_immed,
               dmem_rdata, dmem_ack,
        output imem_addr, imem_rd, opcode, operand, dmem_req, dmem_we, dmem_addr,
               mdr_q, alu_b_sel, acc_we, pc, halted
    );

    modport slave (
        output run, imem_data, mem_read, mem_write, acc_write, pc_load, use_immed,
               dmem_rdata, dmem_ack,
        input  imem_addr, imem_rd, opcode, operand, dmem_req, dmem_we, dmem_addr,
               mdr_q, alu_b_sel, acc_we, pc, halted
    );

endinterface

// File: rtl/cpu_sequencer_pc_reg.sv
// Program counter: loads a jump target (truncated or zero-extended to ADDR_W),
// otherwise increments with natural wrap, and holds when not updating.
module pc_reg #(
    parameter int ADDR_W    = 4,
    parameter int OPERAND_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_update,
    input  logic                 i_load,
    input  logic [OPERAND_W-1:0] i_load_val,
    output logic [ADDR_W-1:0]    o_pc
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_load_addr;

    generate
        if (OPERAND_W > ADDR_W) begin : g_trunc
            logic w_unused_hi;
            assign w_unused_hi = ^i_load_val[OPERAND_W-1:ADDR_W];
            assign w_load_addr = i_load_val[ADDR_W-1:0];
        end else if (OPERAND_W == ADDR_W) begin : g_same
            assign w_load_addr = i_load_val;
        end else begin : g_zext
            assign w_load_addr = {{(ADDR_W-OPERAND_W){1'b0}}, i_load_val};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= '0;
        end else if (i_update) begin
            r_pc <= i_load ? w_load_addr : r_pc + ADDR_W'(1);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/execute sequencer: fetches instruction words, presents them to
// the control unit and turns its strobes into timed memory, accumulator and PC actions.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int OPERAND_W = 4,
    parameter int DATA_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    cpu_sequencer_if.master bus
);

    localparam int INSTR_W = instr_width(OPERAND_W);

    state_t               r_state;
    state_t               w_state_next;
    logic [INSTR_W-1:0]   r_ir;
    logic [DATA_W-1:0]    r_mdr;
    logic [ADDR_W-1:0]    w_pc;
    logic [3:0]           w_opcode;
    logic [OPERAND_W-1:0] w_operand;
    logic                 w_mem_op;
    logic                 w_op_phase;

    assign w_opcode   = r_ir[INSTR_W-1 -: OPCODE_W];
    assign w_operand  = r_ir[OPERAND_W-1:0];
    assign w_mem_op   = bus.mem_read | bus.mem_write;
    assign w_op_phase = (r_state == ST_EXEC) || (r_state == ST_MEM) || (r_state == ST_WB);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ir    <= '0;
            r_mdr   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_DECODE) begin
                r_ir <= bus.imem_data;
            end
            // Acks seen in any other state are deliberately dropped.
            if (r_state == ST_MEM && bus.dmem_ack && bus.mem_read) begin
                r_mdr <= bus.dmem_rdata;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (bus.run) w_state_next = ST_FETCH;
            ST_FETCH:  w_state_next = ST_DECODE;
            ST_DECODE: w_state_next = ST_EXEC;
            ST_EXEC: begin
                if (w_opcode == OP_HALT) w_state_next = ST_HALT;
                else if (w_mem_op)       w_state_next = ST_MEM;
                else                     w_state_next = ST_WB;
            end
            ST_MEM:    if (bus.dmem_ack) w_state_next = ST_WB;
            ST_WB:     w_state_next = bus.run ? ST_FETCH : ST_IDLE;
            ST_HALT:   w_state_next = ST_HALT;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    pc_reg #(
        .ADDR_W    (ADDR_W),
        .OPERAND_W (OPERAND_W)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .i_update   (r_state == ST_WB),
        .i_load     (bus.pc_load),
        .i_load_val (w_operand),
        .o_pc       (w_pc)
    );

    assign bus.imem_addr = w_pc;
    assign bus.imem_rd   = (r_state == ST_FETCH);
    assign bus.opcode    = w_opcode;
    assign bus.operand   = w_operand;
    assign bus.dmem_req  = (r_state == ST_MEM);
    assign bus.dmem_we   = (r_state == ST_MEM) && bus.mem_write;
    assign bus.dmem_addr = w_operand;
    assign bus.mdr_q     = r_mdr;
    assign bus.alu_b_sel = w_op_phase && bus.use_immed;
    assign bus.acc_we    = (r_state == ST_WB) && bus.acc_write;
    assign bus.pc        = w_pc;
    assign bus.halted    = (r_state == ST_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: plays control unit, program memory and
// data RAM, and checks each instruction against an instruction-level model.
module tb_cpu_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0] imem [16];
    logic [3:0] m_pc;
    logic [7:0] m_mdr;
    logic [4:0] w_cu;

    always #5 clk = ~clk;

    cpu_sequencer_if #(.ADDR_W(4), .OPERAND_W(4), .DATA_W(8)) bus ();

    cpu_sequencer #(.ADDR_W(4), .OPERAND_W(4), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Control unit: {mem_read, mem_write, acc_write, pc_load, use_immed}
    function automatic logic [4:0] cu_decode(input logic [3:0] op);
        case (op)
            4'h0, 4'h2, 4'h6, 4'h7, 4'h9: return 5'b10100;
            4'h1, 4'h3, 4'h8, 4'hA:       return 5'b00101;
            4'h4:                         return 5'b01000;
            4'h5:                         return 5'b00010;
            default:                      return 5'b00000;
        endcase
    endfunction

    assign w_cu          = cu_decode(bus.opcode);
    assign bus.mem_read  = w_cu[4];
    assign bus.mem_write = w_cu[3];
    assign bus.acc_write = w_cu[2];
    assign bus.pc_load   = w_cu[1];
    assign bus.use_immed = w_cu[0];

    // Program memory with one-cycle synchronous read.
    always @(posedge clk) begin
        if (bus.imem_rd) bus.imem_data <= imem[bus.imem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.run = 1'b0;
        bus.dmem_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        m_pc = 4'd0;
        m_mdr = 8'd0;
    endtask

    task automatic start_run();
        bus.run = 1'b1;
        tick();
    endtask

    // Runs one instruction, entered with the FETCH cycle currently sampled.
    task automatic run_instr(input int ack_lat, input bit drop_run, input logic [7:0] rdata,
                             output bit fetch_next);
        logic [7:0] ins;
        logic [3:0] op;
        logic [3:0] opd;
        logic [4:0] c;
        ins = imem[m_pc];
        op  = ins[7:4];
        opd = ins[3:0];
        c   = cu_decode(op);
        fetch_next = 1'b0;
        $display("instr pc=%0h word=%02h ack_lat=%0d drop_run=%0d", m_pc, ins, ack_lat, drop_run);
        chk("fetch_rd", 32'(bus.imem_rd), 32'd1);
        chk("fetch_addr", 32'(bus.imem_addr), 32'(m_pc));
        tick();
        chk("decode_rd", 32'(bus.imem_rd), 32'd0);
        chk("decode_acc_we", 32'(bus.acc_we), 32'd0);
        bus.dmem_ack = 1'($urandom_range(0, 1));
        bus.dmem_rdata = 8'($urandom);
        tick();
        bus.dmem_ack = 1'b0;
        chk("exec_opcode", 32'(bus.opcode), 32'(op));
        chk("exec_operand", 32'(bus.operand), 32'(opd));
        chk("exec_req", 32'(bus.dmem_req), 32'd0);
        if (drop_run) bus.run = 1'b0;
        if (op == 4'hF) begin
            tick();
            chk("halted", 32'(bus.halted), 32'd1);
            chk("halt_pc", 32'(bus.pc), 32'(m_pc));
            return;
        end
        chk("exec_bsel", 32'(bus.alu_b_sel), 32'(c[0]));
        if (c[4] || c[3]) begin
            for (int k = 0; k < ack_lat; k++) begin
                tick();
                chk("mem_req", 32'(bus.dmem_req), 32'd1);
                chk("mem_we", 32'(bus.dmem_we), 32'(c[3]));
                chk("mem_addr", 32'(bus.dmem_addr), 32'(opd));
                chk("mem_acc_we", 32'(bus.acc_we), 32'd0);
                if (k == ack_lat - 1) begin
                    bus.dmem_ack = 1'b1;
                    bus.dmem_rdata = rdata;
                end else begin
                    bus.dmem_rdata = 8'($urandom);
                end
            end
            if (c[4]) m_mdr = rdata;
        end
        tick();
        bus.dmem_ack = 1'b0;
        fetch_next = bus.run;
        chk("wb_acc_we", 32'(bus.acc_we), 32'(c[2]));
        chk("wb_req", 32'(bus.dmem_req), 32'd0);
        chk("wb_bsel", 32'(bus.alu_b_sel), 32'(c[0]));
        chk("wb_mdr", 32'(bus.mdr_q), 32'(m_mdr));
        m_pc = c[1] ? opd : m_pc + 4'd1;
        tick();
        chk("post_acc_we", 32'(bus.acc_we), 32'd0);
        chk("post_pc", 32'(bus.pc), 32'(m_pc));
        chk("post_fetch", 32'(bus.imem_rd), 32'(fetch_next));
    endtask

    initial begin
        bit fetch;
        bit drop;
        rst = 1'b1;
        bus.run = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = 8'd0;
        for (int i = 0; i < 16; i++) imem[i] = 8'hB0;

        // Reset state
        do_reset();
        chk("rst_imem_rd", 32'(bus.imem_rd), 32'd0);
        chk("rst_req", 32'(bus.dmem_req), 32'd0);
        chk("rst_we", 32'(bus.dmem_we), 32'd0);
        chk("rst_acc_we", 32'(bus.acc_we), 32'd0);
        chk("rst_pc", 32'(bus.pc), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_mdr", 32'(bus.mdr_q), 32'd0);
        chk("rst_opcode", 32'(bus.opcode), 32'd0);

        // ADDI 3
        imem[0] = 8'h13;
        start_run();
        run_instr(1, 1'b0, 8'h00, fetch);

        // LDA 5, ack after 3 MEM cycles
        do_reset();
        imem[0] = 8'h65;
        start_run();
        run_instr(3, 1'b0, 8'hA5, fetch);
        chk("lda_mdr", 32'(bus.mdr_q), 32'hA5);

        // STA 9, ack in first MEM cycle
        do_reset();
        imem[0] = 8'h49;
        start_run();
        run_instr(1, 1'b0, 8'h3C, fetch);

        // JMP at pc=2 to 7, then JMP to 15 and NOP wrapping to 0
        do_reset();
        for (int i = 0; i < 16; i++) imem[i] = 8'hB0;
        imem[2] = 8'h57;
        imem[7] = 8'h5F;
        start_run();
        for (int i = 0; i < 5; i++) run_instr(1, 1'b0, 8'h00, fetch);
        chk("wrap_pc", 32'(bus.pc), 32'd0);

        // Random program, random ack latency and occasional run drop
        for (int i = 0; i < 16; i++) imem[i] = {4'($urandom_range(0, 14)), 4'($urandom)};
        for (int i = 0; i < 40; i++) begin
            drop = ($urandom_range(0, 7) == 0);
            run_instr(int'($urandom_range(1, 4)), drop, 8'($urandom), fetch);
            if (!fetch) begin
                tick();
                chk("idle_rd", 32'(bus.imem_rd), 32'd0);
                bus.run = 1'b1;
                tick();
            end
        end

        // HALT holds until reset
        do_reset();
        imem[0] = 8'hF0;
        start_run();
        run_instr(1, 1'b0, 8'h00, fetch);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("halt_no_rd", 32'(bus.imem_rd), 32'd0);
        end
        chk("halt_still", 32'(bus.halted), 32'd1);
        chk("halt_pc_frozen", 32'(bus.pc), 32'd0);
        do_reset();
        chk("halt_rst_pc", 32'(bus.pc), 32'd0);
        chk("halt_rst_halted", 32'(bus.halted), 32'd0);

        // Reset during a stalled LDA, then a late ack
        imem[0] = 8'h65;
        start_run();
        tick();
        tick();
        tick();
        chk("stall_req", 32'(bus.dmem_req), 32'd1);
        tick();
        chk("stall_req2", 32'(bus.dmem_req), 32'd1);
        rst = 1'b1;
        bus.run = 1'b0;
        tick();
        rst = 1'b0;
        chk("midmem_rst_req", 32'(bus.dmem_req), 32'd0);
        chk("midmem_rst_pc", 32'(bus.pc), 32'd0);
        chk("midmem_rst_rd", 32'(bus.imem_rd), 32'd0);
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 8'hFF;
        tick();
        bus.dmem_ack = 1'b0;
        tick();
        chk("late_ack_mdr", 32'(bus.mdr_q), 32'd0);
        chk("late_ack_req", 32'(bus.dmem_req), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
